reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 109 ++++++++++
 tb/tb_reg_write_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: two requesters share one write port (Ce one-hot + Din) into a 4-register bank.
// Latency: capture edge -> Ce/Din valid one cycle -> gnt one cycle -> idle; one write per 3 cycles.
// Backpressure: requesters hold req/addr/data until captured; requests are ignored while busy.
// Build option: REG_ARB_FIXED_PRIO_EN gives every tie to A and removes the last-winner register.
module reg_write_arbiter #(
   parameter int DW = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req_a,
   input  logic [1:0]    addr_a,
   input  logic [DW-1:0] data_a,
   input  logic          req_b,
   input  logic [1:0]    addr_b,
   input  logic [DW-1:0] data_b,
   output logic [3:0]    Ce,
   output logic [DW-1:0] Din,
   output logic          gnt_a,
   output logic          gnt_b,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

   state_t          state, state_nx;
   logic [3:0]      ce_nx;
   logic [DW-1:0]   din_nx;
   logic            gnt_a_nx, gnt_b_nx;
   logic            win_b, win_b_nx;
   logic            pick_b;
   logic [1:0]      sel_addr;

`ifdef REG_ARB_FIXED_PRIO_EN
   // Ties always go to A; B wins only when it requests alone.
   always_comb begin
      pick_b = req_b && !req_a;
   end
`else
   logic last_b;

   // Ties go to whichever requester was not granted most recently.
   always_comb begin
      pick_b = req_b && (!req_a || !last_b);
   end

   // Remember the most recent winner; only a capture in IDLE updates it.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         last_b <= 1'b1;
      end else if (state == IDLE && (req_a || req_b)) begin
         last_b <= pick_b;
      end
   end
`endif

   // Next-state and next-output logic; outputs are loaded into registers one edge ahead.
   always_comb begin
      state_nx = state;
      ce_nx    = 4'b0000;
      din_nx   = Din;
      gnt_a_nx = 1'b0;
      gnt_b_nx = 1'b0;
      win_b_nx = win_b;
      sel_addr = pick_b ? addr_b : addr_a;
      case (state)
         IDLE: begin
            if (req_a || req_b) begin
               state_nx = WRITE;
               win_b_nx = pick_b;
               ce_nx    = 4'b0001 << sel_addr;
               din_nx   = pick_b ? data_b : data_a;
            end
         end
         WRITE: begin
            state_nx = ACK;
            gnt_a_nx = !win_b;
            gnt_b_nx = win_b;
         end
         ACK: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset clears them immediately, aborting any write.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         Ce    <= 4'b0000;
         Din   <= '0;
         gnt_a <= 1'b0;
         gnt_b <= 1'b0;
         busy  <= 1'b0;
         win_b <= 1'b0;
      end else begin
         state <= state_nx;
         Ce    <= ce_nx;
         Din   <= din_nx;
         gnt_a <= gnt_a_nx;
         gnt_b <= gnt_b_nx;
         busy  <= (state_nx != IDLE);
         win_b <= win_b_nx;
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: self-checking bench for reg_write_arbiter against a transaction-level model.
// Latency: expectations are queued per write (write cycle, ack cycle, idle cycle).
// Backpressure: stimulus holds or changes requests freely; the model ignores them while a write is queued.
module tb_reg_write_arbiter;

   localparam int DW = 4;

   typedef struct packed {
      logic [3:0]    ce;
      logic [DW-1:0] din;
      logic          ga;
      logic          gb;
      logic          bsy;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          req_a = 1'b0, req_b = 1'b0;
   logic [1:0]    addr_a = '0, addr_b = '0;
   logic [DW-1:0] data_a = '0, data_b = '0;
   logic [3:0]    Ce;
   logic [DW-1:0] Din;
   logic          gnt_a, gnt_b, busy;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   exp_t          exp_q[$];
   exp_t          exp_cur;
   exp_t          obs;
   logic          m_last_b = 1'b1;
   logic [DW-1:0] m_last_din = '0;
   logic [DW-1:0] mem [4];
   logic          mem_vld [4] = '{default: 1'b0};
   logic [DW-1:0] bank [4];

   reg_write_arbiter #(.DW(DW)) dut (
      .CLK(CLK), .RST(RST),
      .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
      .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
      .Ce(Ce), .Din(Din), .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // the register bank the write port drives
   always @(posedge CLK) begin
      for (int i = 0; i < 4; i++) if (Ce[i]) bank[i] <= Din;
   end

   // invariants checked every cycle
   always @(negedge CLK) begin
      n_tests++;
      if (!$onehot0(Ce) || (gnt_a && gnt_b) || ((Ce != 4'b0 || gnt_a || gnt_b) && !busy)) begin
         n_fail++;
         $display("FAIL invariant t=%0t: ce=%b ga=%b gb=%b busy=%b, required onehot0 ce, exclusive gnt, busy when active",
                  $time, Ce, gnt_a, gnt_b, busy);
      end
   end

   task automatic model_reset();
      exp_q.delete();
      m_last_b   = 1'b1;
      m_last_din = '0;
   endtask

   // apply inputs for the coming edge and, if the arbiter is free, queue the resulting write
   task automatic drive(input logic ra, input logic [1:0] aa, input logic [DW-1:0] da,
                        input logic rb, input logic [1:0] ab, input logic [DW-1:0] db);
      logic          w_b;
      logic [1:0]    a;
      logic [DW-1:0] d;
      logic [3:0]    oh;
      req_a = ra; addr_a = aa; data_a = da;
      req_b = rb; addr_b = ab; data_b = db;
      if (exp_q.size() == 0 && (ra || rb)) begin
`ifdef REG_ARB_FIXED_PRIO_EN
         w_b = rb && !ra;
`else
         w_b = (ra && rb) ? !m_last_b : rb;
`endif
         a  = w_b ? ab : aa;
         d  = w_b ? db : da;
         oh = 4'b0000;
         oh[a] = 1'b1;
         m_last_b   = w_b;
         m_last_din = d;
         exp_q.push_back('{ce: oh,      din: d, ga: 1'b0, gb: 1'b0, bsy: 1'b1});
         exp_q.push_back('{ce: 4'b0000, din: d, ga: !w_b, gb: w_b,  bsy: 1'b1});
         exp_q.push_back('{ce: 4'b0000, din: d, ga: 1'b0, gb: 1'b0, bsy: 1'b0});
      end
   endtask

   // expected outputs for the cycle now being observed
   task automatic model_pop();
      if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
      else exp_cur = '{ce: 4'b0000, din: m_last_din, ga: 1'b0, gb: 1'b0, bsy: 1'b0};
      for (int i = 0; i < 4; i++) begin
         if (exp_cur.ce[i]) begin
            mem[i] = exp_cur.din;
            mem_vld[i] = 1'b1;
         end
      end
      obs = {Ce, Din, gnt_a, gnt_b, busy};
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      req_a = 1'b1; addr_a = 2'd3; data_a = 4'hF;
      req_b = 1'b1; addr_b = 2'd1; data_b = 4'h7;
      repeat (3) @(negedge CLK);
      n_tests++;
      if ({Ce, Din, gnt_a, gnt_b, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got ce=%b din=%h ga=%b gb=%b busy=%b, required all zero",
                  Ce, Din, gnt_a, gnt_b, busy);
      end
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      RST = 1'b1;
   endtask

   task automatic test_single_write();
      int busy_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1, 2'd2, 4'hA, 0, 0, 0);
         else drive(0, 0, 0, 0, 0, 0);
         @(negedge CLK);
         model_pop();
         if (busy) busy_cnt++;
         n_tests++;
         if (obs !== exp_cur) begin
            n_fail++;
            $display("FAIL single_model cyc %0d: got %h, required %h", i, obs, exp_cur);
         end
         if (i == 0) begin
            n_tests++;
            if (Ce !== 4'b0100 || Din !== 4'hA) begin
               n_fail++;
               $display("FAIL single_write: got ce=%b din=%h, required ce=0100 din=a", Ce, Din);
            end
         end
         if (i == 1) begin
            n_tests++;
            if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || Ce !== 4'b0) begin
               n_fail++;
               $display("FAIL single_gnt: got ga=%b gb=%b ce=%b, required ga=1 gb=0 ce=0", gnt_a, gnt_b, Ce);
            end
         end
      end
      n_tests++;
      if (busy_cnt != 2) begin
         n_fail++;
         $display("FAIL single_busy_cycles: got %0d, required 2", busy_cnt);
      end
   endtask

   task automatic test_tie();
      logic gl[$];
      do_reset();
      for (int i = 0; i < 15; i++) begin
         if (i < 12) drive(1, 2'd0, 4'h1, 1, 2'd1, 4'h2);
         else drive(0, 0, 0, 0, 0, 0);
         @(negedge CLK);
         model_pop();
         if (gnt_a) gl.push_back(1'b0);
         if (gnt_b) gl.push_back(1'b1);
         n_tests++;
         if (obs !== exp_cur) begin
            n_fail++;
            $display("FAIL tie_model cyc %0d: got %h, required %h", i, obs, exp_cur);
         end
      end
      n_tests++;
      if (gl.size() != 4) begin
         n_fail++;
         $display("FAIL tie_count: got %0d grants, required 4", gl.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_tests++;
`ifdef REG_ARB_FIXED_PRIO_EN
            if (gl[k] !== 1'b0) begin
`else
            if (gl[k] !== k[0]) begin
`endif
               n_fail++;
               $display("FAIL tie_order grant %0d: got %s, required per tie rule", k, gl[k] ? "B" : "A");
            end
         end
      end
   endtask

   task automatic test_same_addr();
      logic ra = 1'b1, rb = 1'b1;
      int   ce3 = 0;
      logic first_b = 1'b0, seen = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(ra, 2'd3, 4'h5, rb, 2'd3, 4'h9);
         @(negedge CLK);
         model_pop();
         if (Ce == 4'b1000) ce3++;
         if ((gnt_a || gnt_b) && !seen) begin
            seen = 1'b1;
            first_b = gnt_b;
         end
         if (gnt_a) ra = 1'b0;
         if (gnt_b) rb = 1'b0;
         n_tests++;
         if (obs !== exp_cur) begin
            n_fail++;
            $display("FAIL same_addr_model cyc %0d: got %h, required %h", i, obs, exp_cur);
         end
      end
      n_tests++;
      if (ce3 != 2 || first_b !== 1'b0 || bank[3] !== 4'h9) begin
         n_fail++;
         $display("FAIL same_addr: got ce3=%0d first_b=%b reg3=%h, required 2 0 9", ce3, first_b, bank[3]);
      end
   endtask

   task automatic test_data_change();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: drive(1, 2'd1, 4'h3, 0, 0, 0);
            1: drive(1, 2'd1, 4'hF, 0, 0, 0);
            default: drive(0, 0, 0, 0, 0, 0);
         endcase
         @(negedge CLK);
         model_pop();
         n_tests++;
         if (obs !== exp_cur) begin
            n_fail++;
            $display("FAIL data_change_model cyc %0d: got %h, required %h", i, obs, exp_cur);
         end
         if (i == 1) begin
            n_tests++;
            if (Din !== 4'h3 || gnt_a !== 1'b1) begin
               n_fail++;
               $display("FAIL data_change: got din=%h ga=%b, required din=3 ga=1", Din, gnt_a);
            end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      drive(1, 2'd1, 4'h6, 0, 0, 0);
      @(posedge CLK);
      #2;
      n_tests++;
      if (Ce !== 4'b0010 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre: got ce=%b busy=%b, required 0010 1", Ce, busy);
      end
      RST = 1'b0;
      #1;
      n_tests++;
      if (Ce !== 4'b0 || busy !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async: got ce=%b busy=%b ga=%b gb=%b, required all 0", Ce, busy, gnt_a, gnt_b);
      end
      model_reset();
      req_a = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         n_tests++;
         if (gnt_a !== 1'b0 || Ce !== 4'b0) begin
            n_fail++;
            $display("FAIL abort_no_gnt cyc %0d: got ga=%b ce=%b, required 0", i, gnt_a, Ce);
         end
      end
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) drive(1, 2'd1, 4'h6, 0, 0, 0);
         else drive(0, 0, 0, 0, 0, 0);
         @(negedge CLK);
         model_pop();
         n_tests++;
         if (obs !== exp_cur) begin
            n_fail++;
            $display("FAIL rerequest_model cyc %0d: got %h, required %h", i, obs, exp_cur);
         end
      end
      n_tests++;
      if (bank[1] !== 4'h6) begin
         n_fail++;
         $display("FAIL rerequest_reg: got %h, required 6", bank[1]);
      end
   endtask

   task automatic test_random();
      logic          ra, rb;
      logic [1:0]    aa, ab;
      logic [DW-1:0] da, db;
      for (int i = 0; i < 400; i++) begin
         ra = ($urandom_range(0, 2) != 0);
         rb = ($urandom_range(0, 2) != 0);
         aa = 2'($urandom_range(0, 3));
         ab = 2'($urandom_range(0, 3));
         da = DW'($urandom_range(0, 15));
         db = DW'($urandom_range(0, 15));
         if (i >= 396) drive(0, 0, 0, 0, 0, 0);
         else drive(ra, aa, da, rb, ab, db);
         @(negedge CLK);
         model_pop();
         n_tests++;
         if (obs !== exp_cur) begin
            n_fail++;
            $display("FAIL random_model cyc %0d: got %h, required %h", i, obs, exp_cur);
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (mem_vld[k]) begin
            n_tests++;
            if (bank[k] !== mem[k]) begin
               n_fail++;
               $display("FAIL random_reg %0d: got %h, required %h", k, bank[k], mem[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_tie();
      test_same_addr();
      test_data_change();
      test_reset_mid_write();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
